// File: rtl/mavg3_pkg.sv
// Shared definitions for the mavg3 smoothing filter: default widths, fill states and rounding
// constant.
package mavg3_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned ROUND_K = 2;

  // Room for 4*(2^w-1)+2 without overflow.
  function automatic int unsigned sum_w(input int unsigned w);
    return w + 2;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    RUN   = 2'd3
  } fill_state_e;

endpackage

// File: rtl/mavg3_taps.sv
// Enable-gated 3-stage delay line; x0 newest, x2 oldest. Async reset and sync clr zero all taps.
module mavg3_taps
  import mavg3_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2
);

  logic [W-1:0] r_x0;
  logic [W-1:0] r_x1;
  logic [W-1:0] r_x2;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (clr) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (en) begin
      r_x2 <= r_x1;
      r_x1 <= r_x0;
      r_x0 <= din;
    end
  end

  assign x0 = r_x0;
  assign x1 = r_x1;
  assign x2 = r_x2;

endmodule

// File: rtl/mavg3_filter.sv
// 1-2-1 binomial smoothing filter with fill tracking and a registered, valid-qualified output.
// Define MAVG3_ROUND_EN for round-half-up; otherwise the weighted sum is truncated.
module mavg3_filter
  import mavg3_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned SUM_W = sum_w(W)
) (
  input  logic         ck,
  input  logic         reset,
  input  logic         clr,
  input  logic         din_valid,
  input  logic [W-1:0] din,
  output logic         dout_valid,
  output logic [W-1:0] dout,
  output logic [1:0]   fill
);

`ifdef MAVG3_ROUND_EN
  localparam logic [SUM_W-1:0] RoundK = SUM_W'(ROUND_K);
`else
  localparam logic [SUM_W-1:0] RoundK = '0;
`endif

  logic         w_accept;
  logic [W-1:0] w_x0;
  logic [W-1:0] w_x1;
  logic [W-1:0] w_x2;
  logic [SUM_W-1:0] w_sum;
  logic         w_pulse;

  fill_state_e r_state;
  fill_state_e w_state_nxt;
  logic        r_req;
  logic        r_dout_valid;
  logic [W-1:0] r_dout;

  assign w_accept = din_valid & ~clr;

  mavg3_taps #(
    .W (W)
  ) u_taps (
    .ck    (ck),
    .reset (reset),
    .clr   (clr),
    .en    (w_accept),
    .din   (din),
    .x0    (w_x0),
    .x1    (w_x1),
    .x2    (w_x2)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = EMPTY;
    end else if (w_accept) begin
      unique case (r_state)
        EMPTY:   w_state_nxt = FILL1;
        FILL1:   w_state_nxt = FILL2;
        FILL2:   w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Taps and state already reflect the sample accepted on the previous edge.
  assign w_sum   = SUM_W'(w_x0) + (SUM_W'(w_x1) << 1) + SUM_W'(w_x2) + RoundK;
  assign w_pulse = r_req & (r_state == RUN);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_req        <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
    end else if (clr) begin
      r_req        <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_req        <= w_accept;
      r_dout_valid <= w_pulse;
      if (w_pulse) begin
        r_dout <= W'(w_sum >> 2);
      end
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign fill       = r_state;

endmodule

// File: tb/tb_mavg3_filter.sv
// Scoreboard bench for mavg3_filter: stimulus pushes hand-computed results, a monitor pops them.
module tb_mavg3_filter;

  logic       ck;
  logic       reset;
  logic       clr;
  logic       din_valid;
  logic [7:0] din;
  logic       dout_valid;
  logic [7:0] dout;
  logic [1:0] fill;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

`ifdef MAVG3_ROUND_EN
  localparam logic [7:0] ExpT6 = 8'h01;
`else
  localparam logic [7:0] ExpT6 = 8'h00;
`endif

  mavg3_filter u_dut (
    .ck         (ck),
    .reset      (reset),
    .clr        (clr),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
    .fill       (fill)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Monitor: every pulse must match the oldest expected result.
  always @(negedge ck) begin
    if (dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse dout=%h, no pulse expected at %0t", dout, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL pulse_dout got=%h want=%h at %0t", dout, e, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input logic [7:0] d);
    din_valid = 1'b1;
    din       = d;
    @(posedge ck);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge ck);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    #2;
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_fill", fill, 0);
    #1;
    reset = 1'b0;
    @(posedge ck);
    #1;

    // 1: basic fill and first result
    sample(8'h10);
    sample(8'h20);
    chk("t1_no_pulse_1", dout_valid, 0);
    exp_q.push_back(8'h20);
    sample(8'h30);
    chk("t1_no_pulse_2", dout_valid, 0);
    chk("t1_fill", fill, 3);
    idle(1);
    chk("t1_pulse", dout_valid, 1);
    idle(2);
    do_reset();

    // 2: full-scale input, back-to-back pulses
    sample(8'hFF);
    sample(8'hFF);
    exp_q.push_back(8'hFF);
    sample(8'hFF);
    exp_q.push_back(8'hFF);
    sample(8'hFF);
    chk("t2_pulse_a", dout_valid, 1);
    idle(1);
    chk("t2_pulse_b", dout_valid, 1);
    idle(2);
    do_reset();

    // 3: sparse samples, dout holds between pulses
    sample(8'h04);
    idle(2);
    sample(8'h08);
    idle(2);
    exp_q.push_back(8'h08);
    sample(8'h0C);
    idle(2);
    chk("t3_hold_valid", dout_valid, 0);
    chk("t3_hold_dout_a", dout, 8'h08);
    idle(1);
    chk("t3_hold_dout_b", dout, 8'h08);

    // 4: clr in RUN drops the coincident sample
    clr       = 1'b1;
    din_valid = 1'b1;
    din       = 8'h55;
    @(posedge ck);
    #1;
    clr       = 1'b0;
    din_valid = 1'b0;
    chk("t4_fill", fill, 0);
    chk("t4_valid", dout_valid, 0);
    chk("t4_x0", u_dut.u_taps.x0, 0);
    chk("t4_x1", u_dut.u_taps.x1, 0);
    chk("t4_x2", u_dut.u_taps.x2, 0);
    chk("t4_dout_kept", dout, 8'h08);
    idle(1);
    chk("t4_no_pulse", dout_valid, 0);
    sample(8'h10);
    sample(8'h20);
    exp_q.push_back(8'h20);
    sample(8'h30);
    chk("t4_fill_run", fill, 3);
    idle(2);

    // 5: async reset between edges in RUN
    #2;
    reset = 1'b1;
    #1;
    chk("t5_dout", dout, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_fill", fill, 0);
    #1;
    reset = 1'b0;
    @(posedge ck);
    #1;
    sample(8'h40);
    sample(8'h40);
    chk("t5_fill2", fill, 2);
    exp_q.push_back(8'h40);
    sample(8'h40);
    idle(2);
    do_reset();

    // 6: rounding versus truncation
    sample(8'h01);
    sample(8'h01);
    exp_q.push_back(ExpT6);
    sample(8'h00);
    idle(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mavg3_filter.md
Name: mavg3_filter

Overview:
- 3-tap binomial smoothing filter, weights 1-2-1 with divide by 4, on an 8-bit sample stream.
- Sits directly downstream of the 8-bit 3-stage shift-register stage and consumes its byte stream, qualified by a valid strobe.
- Holds its own enable-gated tap delay line, tracks pipeline fill, and emits one registered, valid-qualified output per accepted sample once full.

Parameters:
W, 8, sample width in bits (din, dout, taps).
SUM_W, W+2, width of the internal weighted sum; holds the worst case 4*(2^W-1)+2 without overflow.

Ports:
ck  input  1  clock, rising-edge active
reset  input  1  reset, asynchronous, active-high
clr  input  1  synchronous flush of taps and fill state
din_valid  input  1  din is accepted on this rising edge
din  input  W  input sample
dout_valid  output  1  one-cycle pulse: dout holds a new result
dout  output  W  filtered sample
fill  output  2  number of valid taps held, 0..3

Behaviour:
- Taps: x0 is newest, x1 is middle, x2 is oldest.
- On an edge with din_valid=1 and clr=0: x2<=x1, x1<=x0, x0<=din. With din_valid=0 the taps hold.
- Fill FSM encoding: EMPTY=0, FILL1=1, FILL2=2, RUN=3.
  - Each accepted sample advances EMPTY->FILL1->FILL2->RUN.
  - RUN stays in RUN on further samples.
  - The fill port equals the state.
- Output stage:
  - Computes sum = x0 + 2*x1 + x2 + 2 (SUM_W bits, unsigned) combinationally from the updated taps.
  - Registers dout <= sum[SUM_W-1:2] on the edge after the accepting edge.
  - dout_valid<=1 on that edge only if the FSM is in RUN, i.e. the third or later sample has been accepted.
- Latency: sample accepted at edge E produces dout/dout_valid visible after edge E+1.
- Back-to-back din_valid gives back-to-back dout_valid. No backpressure; the consumer must take each pulse.
- dout holds its last value while dout_valid=0.
- No overflow is possible: max sum = 1022 gives dout = 255.
- clr (synchronous) has priority over din_valid:
  - taps<=0, state<=EMPTY, dout_valid<=0 on that edge, and on the following edge no pulse is generated for any sample from the clr edge.
  - dout is not cleared.
  - The first sample accepted after clr is accepted on the next edge with clr=0.
- reset (asynchronous) clears immediately, independent of ck:
  - taps=0, state=EMPTY, fill=0, dout=0, dout_valid=0, plus any pending output-stage request.
- Reset mid-stream discards all in-flight samples. After release, 3 new samples are required before the first dout_valid.
- Simultaneous reset and din_valid: reset wins and the sample is lost.

Optional Feature:
- Macro: MAVG3_ROUND_EN.
- Defined: the +2 rounding constant is included (round-half-up).
- Undefined: the constant is omitted, so dout = (x0+2*x1+x2)>>2 (truncation).
- Latency, handshake and reset behaviour are identical in both builds.

Decomposition:
- Package mavg3_pkg holds:
  - default W, and SUM_W derivation
  - fill-state constants EMPTY/FILL1/FILL2/RUN (2-bit)
  - rounding constant ROUND_K=2
- Sub-module mavg3_taps: enable-gated 3-stage W-bit delay line.
  - Ports: ck, reset, clr, en, din, x0, x1, x2.
  - Same async-reset and clr-to-zero rules as the parent.
- The parent instantiates mavg3_taps and adds the FSM and output stage.

Test Plan:
1. Reset, then din 8'h10, 8'h20, 8'h30 on consecutive valid cycles -> no dout_valid after the first two; one edge after the third, dout_valid=1, dout=8'h20 (130>>2); fill=3.
2. Three consecutive 8'hFF -> dout=8'hFF, no wrap; a fourth 8'hFF -> second consecutive pulse, dout=8'hFF.
3. Samples 8'h04, 8'h08, 8'h0C with two idle cycles between each -> exactly one dout_valid pulse, one edge after 8'h0C is accepted, dout=8'h08; dout holds 8'h08 during the idle cycles that follow.
4. In RUN, assert clr together with din_valid=1, din=8'h55 -> sample dropped, fill=0, no pulse; the next three samples are required before dout_valid; taps read 0.
5. Assert reset between clock edges in RUN -> dout=0, dout_valid=0, fill=0 immediately, without a clock edge; after release, no pulse until the third accepted sample.
6. din 8'h01, 8'h01, 8'h00 -> dout=8'h01 with MAVG3_ROUND_EN defined, dout=8'h00 without it.
